fifo_multi: RTL and testbench

Parametrised multi-channel FIFO, successor to the single-channel mono FIFO. Incoming words are steered into one of `2**CH_BITS` independent circular queues by the tag bits in their most significant positions. A read port drains a selected channel. It sits between the tagged-token producer and the per-actor consumers of the dataflow fabric. Each channel has its own full, empty and overflow status.

---
 rtl/fifo_multi_pkg.sv | 19 +
 rtl/fifo_multi_chan.sv | 66 ++++++
 rtl/fifo_multi.sv | 74 +++++++
 tb/tb_fifo_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fifo_multi_pkg.sv
// Shared constants, count typedef and clog2 helper for the multi-channel FIFO.
// Optional feature macro: FIFO_MULTI_FWFT_EN (first-word-fall-through read port).
package fifo_multi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_CH_BITS = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Occupancy count for a default-depth channel: one extra bit so DEPTH fits.
  typedef logic [clog2(DEF_DEPTH):0] cnt_t;

endpackage

// File: rtl/fifo_multi_chan.sv
// One circular queue: storage, read/write pointers, occupancy and registered
// full/empty/almost_full/overflow status.
module fifo_multi_chan
  import fifo_multi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              pop
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              push;

  // A full queue still accepts a write when the same edge pops a word.
  always_comb begin
    pop        = rd_en & ~empty;
    push       = wr_en & (~full | pop);
    count_next = count + CW'(push) - CW'(pop);
  end

  assign head = mem[rptr];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      empty       <= (count_next == '0);
      almost_full <= (count_next >= CW'(AF_LEVEL));
      overflow    <= wr_en & ~push;
    end
  end

  always_ff @(posedge ck) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/fifo_multi.sv
// Multi-channel FIFO: words are steered by their top tag bits into NCH queues,
// a single read port drains the channel chosen by rd_ch.
// Optional feature macro: FIFO_MULTI_FWFT_EN (combinational head on dataout).
module fifo_multi
  import fifo_multi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CH_BITS  = DEF_CH_BITS,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [DATA_W-1:0]    datain,
  input  logic                 rd,
  input  logic [CH_BITS-1:0]   rd_ch,
  output logic [DATA_W-1:0]    dataout,
  output logic [2**CH_BITS-1:0] full,
  output logic [2**CH_BITS-1:0] empty,
  output logic [2**CH_BITS-1:0] almost_full,
  output logic [2**CH_BITS-1:0] overflow,
  output logic                 underflow
);

  localparam int NCH = 2**CH_BITS;

  logic [CH_BITS-1:0] tag;
  logic [NCH-1:0]     wr_en;
  logic [NCH-1:0]     rd_en;
  logic [NCH-1:0]     pop;
  logic [DATA_W-1:0]  heads [NCH];

  assign tag = datain[DATA_W-1 -: CH_BITS];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign wr_en[c] = wr & (tag == CH_BITS'(c));
    assign rd_en[c] = rd & (rd_ch == CH_BITS'(c));

    fifo_multi_chan #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .AF_LEVEL(AF_LEVEL)
    ) u_chan (
      .ck         (ck),
      .rst_n      (rst_n),
      .wr_en      (wr_en[c]),
      .rd_en      (rd_en[c]),
      .din        (datain),
      .head       (heads[c]),
      .full       (full[c]),
      .empty      (empty[c]),
      .almost_full(almost_full[c]),
      .overflow   (overflow[c]),
      .pop        (pop[c])
    );
  end

`ifdef FIFO_MULTI_FWFT_EN
  // Head of the selected queue is visible now; rd only acknowledges it.
  assign dataout = empty[rd_ch] ? '0 : heads[rd_ch];
`else
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) dataout <= '0;
    else if (|pop) dataout <= heads[rd_ch];
  end
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) underflow <= 1'b0;
    else        underflow <= rd & empty[rd_ch];
  end

endmodule

// File: tb/tb_fifo_multi.sv
// Directed plus randomized bench for fifo_multi (default build, registered read)
// checked against a queue-based reference model.
module tb_fifo_multi;

  logic       ck;
  logic       rst_n;
  logic       wr;
  logic [7:0] datain;
  logic       rd;
  logic       rd_ch;
  logic [7:0] dataout;
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] almost_full;
  logic [1:0] overflow;
  logic       underflow;

  fifo_multi dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .wr         (wr),
    .datain     (datain),
    .rd         (rd),
    .rd_ch      (rd_ch),
    .dataout    (dataout),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // reference model state
  logic [7:0] mq [2][$];
  logic [7:0] m_dout;
  logic [1:0] m_ovf;
  logic       m_udf;
  int         vec;
  int         err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [1:0] ef, ee, ea;
    for (int c = 0; c < 2; c++) begin
      ef[c] = (mq[c].size() == 8);
      ee[c] = (mq[c].size() == 0);
      ea[c] = (mq[c].size() >= 6);
    end
    chk({where, ".dataout"},     dataout,              m_dout);
    chk({where, ".full"},        {6'd0, full},         {6'd0, ef});
    chk({where, ".empty"},       {6'd0, empty},        {6'd0, ee});
    chk({where, ".almost_full"}, {6'd0, almost_full},  {6'd0, ea});
    chk({where, ".overflow"},    {6'd0, overflow},     {6'd0, m_ovf});
    chk({where, ".underflow"},   {7'd0, underflow},    {7'd0, m_udf});
  endtask

  // driver: one clock cycle of stimulus, model update, then check
  task automatic step(input string where, input logic w, input logic [7:0] d,
                      input logic r, input logic rc);
    int  c;
    int  sz_c;
    int  sz_r;
    bit  do_pop;
    bit  do_push;
    @(negedge ck);
    wr = w; datain = d; rd = r; rd_ch = rc;
    @(posedge ck);
    c       = int'(d[7]);
    sz_c    = mq[c].size();
    sz_r    = mq[rc].size();
    do_pop  = r && (sz_r > 0);
    do_push = w && ((sz_c < 8) || (do_pop && (int'(rc) == c)));
    m_ovf   = (w && !do_push) ? (2'b01 << c) : 2'b00;
    m_udf   = r && (sz_r == 0);
    if (do_pop)  m_dout = mq[rc].pop_front();
    if (do_push) mq[c].push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
    check_all(where);
  endtask

  task automatic async_reset(input string where);
    @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    mq[0].delete();
    mq[1].delete();
    m_dout = 8'h00; m_ovf = 2'b00; m_udf = 1'b0;
    check_all(where);
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    int wprob;
    vec = 0; err = 0;
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0; rd_ch = 1'b0; datain = 8'h00;
    m_dout = 8'h00; m_ovf = 2'b00; m_udf = 1'b0;

    async_reset("reset");

    // fill ch1, ninth write overflows, ch0 untouched
    for (int i = 1; i <= 9; i++) step("fill", 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);

    // read and write the full channel together, then drain it
    step("full_rw", 1'b1, 8'h8A, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step("drain1", 1'b0, 8'h00, 1'b1, 1'b1);

    // read of empty ch0
    step("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf_after", 1'b0, 8'h00, 1'b0, 1'b0);

    // ordering across channels
    step("ord_w", 1'b1, 8'h01, 1'b0, 1'b0);
    step("ord_w", 1'b1, 8'h82, 1'b0, 1'b0);
    step("ord_w", 1'b1, 8'h02, 1'b0, 1'b0);
    step("ord_r0", 1'b0, 8'h00, 1'b1, 1'b0);
    step("ord_r0", 1'b0, 8'h00, 1'b1, 1'b0);
    step("ord_r1", 1'b0, 8'h00, 1'b1, 1'b1);

    // wrap-around on ch0
    for (int i = 0; i < 20; i++) begin
      step("wrap_w", 1'b1, 8'(i), 1'b0, 1'b0);
      step("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // random traffic alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      wprob = ((i / 50) % 2 == 0) ? 80 : 30;
      step("rand", ($urandom_range(0, 99) < wprob), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < (100 - wprob)), 1'($urandom_range(0, 1)));
    end

    // mid-operation reset with a non-zero dataout and queued words
    step("pre_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 8'h5B, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 8'hC3, 1'b1, 1'b0);
    async_reset("mid_reset");

    for (int i = 0; i < 60; i++) begin
      step("rand2", ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
